// File: rtl/memu_stage_pkg.sv
// memu_stage_pkg: shared definitions for the memory-access stage.
//   - opcode constants for the memory instructions (instr[15:12])
//   - FSM state encodings of memu_stage
//   - small opcode classification helpers
package memu_stage_pkg;

  localparam logic [3:0] OP_LW = 4'b0100;
  localparam logic [3:0] OP_SW = 4'b0101;
  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  localparam logic [1:0] MEMU_IDLE  = 2'b00;
  localparam logic [1:0] MEMU_ACC   = 2'b01;
  localparam logic [1:0] MEMU_MULTI = 2'b10;

  // True for opcodes whose completion writes a register from memory.
  function automatic logic op_is_load(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_LM);
  endfunction

  // True for the multi-register transfer opcodes.
  function automatic logic op_is_multi(input logic [3:0] op);
    return (op == OP_LM) || (op == OP_SM);
  endfunction

endpackage

// File: rtl/memu_lmsm_seq.sv
// memu_lmsm_seq: LM/SM beat sequencer.
//   Holds the remaining register mask and the current beat address. The
//   lowest set mask bit is the register of the current beat; each accepted
//   beat (adv) clears that bit and advances the address by one (wrapping).
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   load           capture load_mask/load_base (start of a transfer)
//   load_mask      register mask (bit i selects register i)
//   load_base      base word address
//   adv            current beat completed (ack seen)
//   cur_idx        register index of the current beat
//   last_beat      current beat is the final one
//   beat_addr      word address of the current beat
module memu_lmsm_seq
  import memu_stage_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int NREG   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load,
  input  logic [NREG-1:0]   load_mask,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              adv,
  output logic [2:0]        cur_idx,
  output logic              last_beat,
  output logic [ADDR_W-1:0] beat_addr
);

  logic [NREG-1:0]   mask_r;
  logic [ADDR_W-1:0] addr_r;
  logic [NREG-1:0]   low_bit_s;

  // Lowest-set-bit priority encoder (descending scan so the lowest index wins).
  always_comb begin
    cur_idx = 3'd0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (mask_r[i]) begin
        cur_idx = 3'(i);
      end else begin
        cur_idx = cur_idx;
      end
    end
  end

  // Isolate the lowest set bit; the beat is last when no other bit remains.
  assign low_bit_s = mask_r & (~mask_r + {{(NREG-1){1'b0}}, 1'b1});
  assign last_beat = ((mask_r & ~low_bit_s) == {NREG{1'b0}});
  assign beat_addr = addr_r;

  // Mask and beat address: load at transfer start, clear bit / step on ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask_r <= {NREG{1'b0}};
      addr_r <= {ADDR_W{1'b0}};
    end else if (load) begin
      mask_r <= load_mask;
      addr_r <= load_base;
    end else if (adv) begin
      mask_r <= mask_r & ~low_bit_s;
      addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      mask_r <= mask_r;
      addr_r <= addr_r;
    end
  end

endmodule

// File: rtl/memu_stage.sv
// memu_stage: memory-access stage of the 16-bit pipeline.
//   Passes ALU results to writeback (1 cycle), performs LW/SW through a
//   req/ack data-memory port and, when MEMU_LMSM_EN is defined, sequences
//   LM/SM multi-register transfers. Without MEMU_LMSM_EN, LM/SM retire in one
//   cycle with no memory access and pulse memu_illegal_o.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   ex_*                         execute-stage result (valid, instr, pc,
//                                wb value / store data, rd index, address)
//   memu_stall_o                 upstream hold while an access is in flight
//   load_pending_o               load (LW/LM) outstanding, to exec
//   dmem_req/we/addr/wdata_o     data-memory request, held until ack
//   dmem_ack_i, dmem_rdata_i     memory completion and read data
//   rf_sm_idx_o, rf_sm_val_i     RF read port for SM beats
//   wb_*                         writeback (valid pulse, rd, value, pc, instr)
//   fwd_mem_*                    MEM-stage forwarding, mirrors wb_*
//   memu_illegal_o               pulse: LM/SM retired without execution
module memu_stage
  import memu_stage_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int NREG   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ex_valid_i,
  input  logic [15:0]       ex_instr_i,
  input  logic [15:0]       ex_pc_i,
  input  logic [DATA_W-1:0] ex_wb_val_i,
  input  logic [2:0]        ex_rd_idx_i,
  input  logic [ADDR_W-1:0] ex_addr_i,
  output logic              memu_stall_o,
  output logic              load_pending_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic [2:0]        rf_sm_idx_o,
  input  logic [DATA_W-1:0] rf_sm_val_i,
  output logic              wb_valid_o,
  output logic [2:0]        wb_rd_idx_o,
  output logic [DATA_W-1:0] wb_val_o,
  output logic [15:0]       wb_pc_o,
  output logic [15:0]       wb_instr_o,
  output logic              fwd_mem_valid_o,
  output logic [2:0]        fwd_mem_rd_o,
  output logic [DATA_W-1:0] fwd_mem_val_o,
  output logic              memu_illegal_o
);

  logic [1:0]        state_r;
  logic [15:0]       op_instr_r;
  logic [15:0]       op_pc_r;
  logic [2:0]        op_rd_r;
  logic [ADDR_W-1:0] acc_addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [3:0]        ex_op_s;
  logic [3:0]        cur_op_s;
  logic              final_ack_s;

  assign ex_op_s  = ex_instr_i[15:12];
  assign cur_op_s = op_instr_r[15:12];

`ifdef MEMU_LMSM_EN
  logic [NREG-1:0]   ex_mask_s;
  logic              seq_load_s;
  logic              seq_adv_s;
  logic [2:0]        seq_idx_s;
  logic              seq_last_s;
  logic [ADDR_W-1:0] seq_addr_s;

  assign ex_mask_s  = ex_instr_i[NREG-1:0];
  assign seq_load_s = (state_r == MEMU_IDLE) && ex_valid_i && op_is_multi(ex_op_s)
                      && (ex_mask_s != {NREG{1'b0}});
  assign seq_adv_s  = (state_r == MEMU_MULTI) && dmem_ack_i;

  memu_lmsm_seq #(
    .ADDR_W (ADDR_W),
    .NREG   (NREG)
  ) u_lmsm_seq (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load      (seq_load_s),
    .load_mask (ex_mask_s),
    .load_base (ex_addr_i),
    .adv       (seq_adv_s),
    .cur_idx   (seq_idx_s),
    .last_beat (seq_last_s),
    .beat_addr (seq_addr_s)
  );

  // SM write data comes straight from the RF read port during the beat.
  assign final_ack_s  = dmem_ack_i && ((state_r == MEMU_ACC) ||
                        ((state_r == MEMU_MULTI) && seq_last_s));
  assign rf_sm_idx_o  = (state_r == MEMU_MULTI) ? seq_idx_s : 3'd0;
  assign dmem_addr_o  = (state_r == MEMU_MULTI) ? seq_addr_s : acc_addr_r;
  assign dmem_wdata_o = ((state_r == MEMU_MULTI) && dmem_we_o) ? rf_sm_val_i : wdata_r;
`else
  logic [NREG-1:0]   unused_mask_s;
  logic              unused_rf_s;

  assign unused_mask_s = ex_instr_i[NREG-1:0];
  assign unused_rf_s   = ^rf_sm_val_i;
  assign final_ack_s   = dmem_ack_i && (state_r == MEMU_ACC);
  assign rf_sm_idx_o   = 3'd0;
  assign dmem_addr_o   = acc_addr_r;
  assign dmem_wdata_o  = wdata_r;
`endif

  assign memu_stall_o    = (state_r != MEMU_IDLE);
  // Gated by rst_i so the combinational output is 0 throughout reset.
  assign load_pending_o  = !rst_i &&
                           (((state_r == MEMU_IDLE) && ex_valid_i && op_is_load(ex_op_s)) ||
                            ((state_r != MEMU_IDLE) && op_is_load(cur_op_s) && !final_ack_s));
  assign fwd_mem_valid_o = wb_valid_o;
  assign fwd_mem_rd_o    = wb_rd_idx_o;
  assign fwd_mem_val_o   = wb_val_o;

  // Stage FSM, memory request registers and writeback registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r        <= MEMU_IDLE;
      op_instr_r     <= 16'h0000;
      op_pc_r        <= 16'h0000;
      op_rd_r        <= 3'd0;
      acc_addr_r     <= {ADDR_W{1'b0}};
      wdata_r        <= {DATA_W{1'b0}};
      dmem_req_o     <= 1'b0;
      dmem_we_o      <= 1'b0;
      wb_valid_o     <= 1'b0;
      wb_rd_idx_o    <= 3'd0;
      wb_val_o       <= {DATA_W{1'b0}};
      wb_pc_o        <= 16'h0000;
      wb_instr_o     <= 16'h0000;
      memu_illegal_o <= 1'b0;
    end else begin
      wb_valid_o     <= 1'b0;
      memu_illegal_o <= 1'b0;
      case (state_r)
        MEMU_IDLE: begin
          if (ex_valid_i) begin
            op_instr_r <= ex_instr_i;
            op_pc_r    <= ex_pc_i;
            op_rd_r    <= ex_rd_idx_i;
            case (ex_op_s)
              OP_LW, OP_SW: begin
                state_r    <= MEMU_ACC;
                dmem_req_o <= 1'b1;
                dmem_we_o  <= (ex_op_s == OP_SW);
                acc_addr_r <= ex_addr_i;
                wdata_r    <= (ex_op_s == OP_SW) ? ex_wb_val_i : {DATA_W{1'b0}};
              end
              OP_LM, OP_SM: begin
`ifdef MEMU_LMSM_EN
                if (ex_mask_s != {NREG{1'b0}}) begin
                  state_r    <= MEMU_MULTI;
                  dmem_req_o <= 1'b1;
                  dmem_we_o  <= (ex_op_s == OP_SM);
                  wdata_r    <= {DATA_W{1'b0}};
                end else begin
                  // Empty mask retires like a non-memory op, without a write.
                  wb_pc_o    <= ex_pc_i;
                  wb_instr_o <= ex_instr_i;
                end
`else
                wb_pc_o        <= ex_pc_i;
                wb_instr_o     <= ex_instr_i;
                memu_illegal_o <= 1'b1;
`endif
              end
              default: begin
                wb_valid_o  <= 1'b1;
                wb_rd_idx_o <= ex_rd_idx_i;
                wb_val_o    <= ex_wb_val_i;
                wb_pc_o     <= ex_pc_i;
                wb_instr_o  <= ex_instr_i;
              end
            endcase
          end
        end
        MEMU_ACC: begin
          if (dmem_ack_i) begin
            state_r    <= MEMU_IDLE;
            dmem_req_o <= 1'b0;
            dmem_we_o  <= 1'b0;
            wb_pc_o    <= op_pc_r;
            wb_instr_o <= op_instr_r;
            if (cur_op_s == OP_LW) begin
              wb_valid_o  <= 1'b1;
              wb_rd_idx_o <= op_rd_r;
              wb_val_o    <= dmem_rdata_i;
            end
          end
        end
`ifdef MEMU_LMSM_EN
        MEMU_MULTI: begin
          if (dmem_ack_i) begin
            wb_pc_o    <= op_pc_r;
            wb_instr_o <= op_instr_r;
            if (cur_op_s == OP_LM) begin
              wb_valid_o  <= 1'b1;
              wb_rd_idx_o <= seq_idx_s;
              wb_val_o    <= dmem_rdata_i;
            end
            if (seq_last_s) begin
              state_r    <= MEMU_IDLE;
              dmem_req_o <= 1'b0;
              dmem_we_o  <= 1'b0;
            end
          end
        end
`endif
        default: begin
          state_r    <= MEMU_IDLE;
          dmem_req_o <= 1'b0;
          dmem_we_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memu_stage.sv
// tb_memu_stage: directed self-checking bench for memu_stage.
module tb_memu_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_valid_i;
  logic [15:0] ex_instr_i;
  logic [15:0] ex_pc_i;
  logic [15:0] ex_wb_val_i;
  logic [2:0]  ex_rd_idx_i;
  logic [15:0] ex_addr_i;
  logic        memu_stall_o;
  logic        load_pending_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [15:0] dmem_addr_o;
  logic [15:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [15:0] dmem_rdata_i;
  logic [2:0]  rf_sm_idx_o;
  logic [15:0] rf_sm_val_i;
  logic        wb_valid_o;
  logic [2:0]  wb_rd_idx_o;
  logic [15:0] wb_val_o;
  logic [15:0] wb_pc_o;
  logic [15:0] wb_instr_o;
  logic        fwd_mem_valid_o;
  logic [2:0]  fwd_mem_rd_o;
  logic [15:0] fwd_mem_val_o;
  logic        memu_illegal_o;

  int checks_n = 0;
  int fails_n  = 0;

  // Register file model: register i reads as 0xA000 + i.
  assign rf_sm_val_i = 16'hA000 | {13'd0, rf_sm_idx_o};

  always #5 clk_i = ~clk_i;

  memu_stage dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .ex_valid_i      (ex_valid_i),
    .ex_instr_i      (ex_instr_i),
    .ex_pc_i         (ex_pc_i),
    .ex_wb_val_i     (ex_wb_val_i),
    .ex_rd_idx_i     (ex_rd_idx_i),
    .ex_addr_i       (ex_addr_i),
    .memu_stall_o    (memu_stall_o),
    .load_pending_o  (load_pending_o),
    .dmem_req_o      (dmem_req_o),
    .dmem_we_o       (dmem_we_o),
    .dmem_addr_o     (dmem_addr_o),
    .dmem_wdata_o    (dmem_wdata_o),
    .dmem_ack_i      (dmem_ack_i),
    .dmem_rdata_i    (dmem_rdata_i),
    .rf_sm_idx_o     (rf_sm_idx_o),
    .rf_sm_val_i     (rf_sm_val_i),
    .wb_valid_o      (wb_valid_o),
    .wb_rd_idx_o     (wb_rd_idx_o),
    .wb_val_o        (wb_val_o),
    .wb_pc_o         (wb_pc_o),
    .wb_instr_o      (wb_instr_o),
    .fwd_mem_valid_o (fwd_mem_valid_o),
    .fwd_mem_rd_o    (fwd_mem_rd_o),
    .fwd_mem_val_o   (fwd_mem_val_o),
    .memu_illegal_o  (memu_illegal_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      fails_n++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present one instruction; caller advances the clock.
  task automatic issue(input logic [15:0] instr, input logic [15:0] pc, input logic [15:0] val,
                       input logic [2:0] rd, input logic [15:0] addr);
    ex_valid_i  = 1'b1;
    ex_instr_i  = instr;
    ex_pc_i     = pc;
    ex_wb_val_i = val;
    ex_rd_idx_i = rd;
    ex_addr_i   = addr;
    #1;
  endtask

  task automatic check_wb(input string tag, input logic v, input logic [2:0] rd, input logic [15:0] val);
    check_eq({tag, "_wbv"}, wb_valid_o, v);
    check_eq({tag, "_fwdv"}, fwd_mem_valid_o, v);
    if (v) begin
      check_eq({tag, "_rd"}, wb_rd_idx_o, rd);
      check_eq({tag, "_val"}, wb_val_o, val);
      check_eq({tag, "_fwdrd"}, fwd_mem_rd_o, rd);
      check_eq({tag, "_fwdval"}, fwd_mem_val_o, val);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    ex_valid_i = 1'b0; ex_instr_i = 16'h0000; ex_pc_i = 16'h0000; ex_wb_val_i = 16'h0000;
    ex_rd_idx_i = 3'd0; ex_addr_i = 16'h0000; dmem_ack_i = 1'b0; dmem_rdata_i = 16'h0000;
    tick(); tick();
    check_eq("rst_req", dmem_req_o, 1'b0);
    check_eq("rst_stall", memu_stall_o, 1'b0);
    check_eq("rst_lp", load_pending_o, 1'b0);
    check_eq("rst_wb", wb_valid_o, 1'b0);
    check_eq("rst_ill", memu_illegal_o, 1'b0);
    rst_i = 1'b0;
    tick();

    // 1: ALU result passes through with latency 1 and no stall
    issue(16'h1000, 16'h0002, 16'h1234, 3'd3, 16'h0000);
    check_eq("t1_stall0", memu_stall_o, 1'b0);
    check_eq("t1_lp0", load_pending_o, 1'b0);
    tick(); ex_valid_i = 1'b0;
    check_wb("t1", 1'b1, 3'd3, 16'h1234);
    check_eq("t1_pc", wb_pc_o, 16'h0002);
    check_eq("t1_stall1", memu_stall_o, 1'b0);
    tick();
    check_eq("t1_pulse", wb_valid_o, 1'b0);

    // 2: LW with ack three cycles after req
    issue(16'h4000, 16'h0010, 16'h0000, 3'd2, 16'h0040);
    check_eq("t2_lp_idle", load_pending_o, 1'b1);
    tick(); ex_valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_eq("t2_req", dmem_req_o, 1'b1);
      check_eq("t2_addr", dmem_addr_o, 16'h0040);
      check_eq("t2_we", dmem_we_o, 1'b0);
      check_eq("t2_stall", memu_stall_o, 1'b1);
      check_eq("t2_lp", load_pending_o, 1'b1);
      check_eq("t2_nowb", wb_valid_o, 1'b0);
      if (c == 2) begin
        dmem_ack_i = 1'b1; dmem_rdata_i = 16'hBEEF;
        #1;
        check_eq("t2_lp_ack", load_pending_o, 1'b0);
      end
      tick();
    end
    dmem_ack_i = 1'b0;
    check_wb("t2", 1'b1, 3'd2, 16'hBEEF);
    check_eq("t2_req_done", dmem_req_o, 1'b0);
    check_eq("t2_stall_done", memu_stall_o, 1'b0);
    check_eq("t2_pc", wb_pc_o, 16'h0010);

    // 3: SW at top of memory, zero-wait ack
    issue(16'h5000, 16'h0014, 16'h00AA, 3'd1, 16'hFFFF);
    check_eq("t3_lp", load_pending_o, 1'b0);
    tick(); ex_valid_i = 1'b0;
    dmem_ack_i = 1'b1;
    #1;
    check_eq("t3_req", dmem_req_o, 1'b1);
    check_eq("t3_we", dmem_we_o, 1'b1);
    check_eq("t3_addr", dmem_addr_o, 16'hFFFF);
    check_eq("t3_wdata", dmem_wdata_o, 16'h00AA);
    check_eq("t3_stall", memu_stall_o, 1'b1);
    tick(); dmem_ack_i = 1'b0;
    check_eq("t3_req_done", dmem_req_o, 1'b0);
    check_eq("t3_nowb", wb_valid_o, 1'b0);
    check_eq("t3_idle", memu_stall_o, 1'b0);
    check_eq("t3_instr", wb_instr_o, 16'h5000);

`ifdef MEMU_LMSM_EN
    // 4a: LM wrapping base, mask 0x05 -> R0 @FFFE, R2 @FFFF
    issue(16'h6005, 16'h0020, 16'h0000, 3'd0, 16'hFFFE);
    check_eq("t4_lp_idle", load_pending_o, 1'b1);
    tick(); ex_valid_i = 1'b0;
    check_eq("t4_req0", dmem_req_o, 1'b1);
    check_eq("t4_addr0", dmem_addr_o, 16'hFFFE);
    check_eq("t4_we0", dmem_we_o, 1'b0);
    dmem_ack_i = 1'b1; dmem_rdata_i = 16'h1111;
    #1;
    check_eq("t4_lp0", load_pending_o, 1'b1);
    tick();
    check_wb("t4b0", 1'b1, 3'd0, 16'h1111);
    check_eq("t4_req1", dmem_req_o, 1'b1);
    check_eq("t4_addr1", dmem_addr_o, 16'hFFFF);
    dmem_rdata_i = 16'h2222;
    #1;
    check_eq("t4_lp1", load_pending_o, 1'b0);
    tick(); dmem_ack_i = 1'b0;
    check_wb("t4b1", 1'b1, 3'd2, 16'h2222);
    check_eq("t4_req_done", dmem_req_o, 1'b0);
    check_eq("t4_idle", memu_stall_o, 1'b0);

    // 4b: SM mask 0x00 -> 1-cycle retire, no access
    issue(16'h7000, 16'h0024, 16'h0000, 3'd0, 16'h0300);
    tick(); ex_valid_i = 1'b0;
    check_eq("t4e_req", dmem_req_o, 1'b0);
    check_eq("t4e_stall", memu_stall_o, 1'b0);
    check_eq("t4e_wb", wb_valid_o, 1'b0);
    check_eq("t4e_instr", wb_instr_o, 16'h7000);

    // 4c: SM mask 0x82 -> R1 @0100, R7 @0101, data from RF port
    issue(16'h7082, 16'h0028, 16'h0000, 3'd0, 16'h0100);
    tick(); ex_valid_i = 1'b0;
    check_eq("t4s_idx0", rf_sm_idx_o, 3'd1);
    check_eq("t4s_addr0", dmem_addr_o, 16'h0100);
    check_eq("t4s_wd0", dmem_wdata_o, 16'hA001);
    check_eq("t4s_we0", dmem_we_o, 1'b1);
    dmem_ack_i = 1'b1;
    tick();
    check_eq("t4s_idx1", rf_sm_idx_o, 3'd7);
    check_eq("t4s_addr1", dmem_addr_o, 16'h0101);
    check_eq("t4s_wd1", dmem_wdata_o, 16'hA007);
    check_eq("t4s_nowb", wb_valid_o, 1'b0);
    tick(); dmem_ack_i = 1'b0;
    check_eq("t4s_req_done", dmem_req_o, 1'b0);
    check_eq("t4s_idle", memu_stall_o, 1'b0);
`else
    // 6: LM without the sequencer -> illegal pulse, no access, no wb
    issue(16'h60FF, 16'h0020, 16'h0000, 3'd0, 16'h0200);
    tick(); ex_valid_i = 1'b0;
    check_eq("t6_req", dmem_req_o, 1'b0);
    check_eq("t6_ill", memu_illegal_o, 1'b1);
    check_eq("t6_wb", wb_valid_o, 1'b0);
    check_eq("t6_stall", memu_stall_o, 1'b0);
    check_eq("t6_instr", wb_instr_o, 16'h60FF);
    check_eq("t6_smidx", rf_sm_idx_o, 3'd0);
    tick();
    check_eq("t6_ill_pulse", memu_illegal_o, 1'b0);
`endif

    // 5: reset while LW waits for ack
    issue(16'h4000, 16'h0030, 16'h0000, 3'd5, 16'h0123);
    tick(); ex_valid_i = 1'b0;
    check_eq("t5_req", dmem_req_o, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    check_eq("t5_req_rst", dmem_req_o, 1'b0);
    check_eq("t5_addr_rst", dmem_addr_o, 16'h0000);
    check_eq("t5_stall_rst", memu_stall_o, 1'b0);
    check_eq("t5_lp_rst", load_pending_o, 1'b0);
    check_eq("t5_pc_rst", wb_pc_o, 16'h0000);
    check_eq("t5_instr_rst", wb_instr_o, 16'h0000);
    tick(); rst_i = 1'b0;
    dmem_ack_i = 1'b1; dmem_rdata_i = 16'hDEAD;
    tick(); dmem_ack_i = 1'b0;
    check_eq("t5_late_ack_wb", wb_valid_o, 1'b0);
    check_eq("t5_late_ack_req", dmem_req_o, 1'b0);
    issue(16'h2000, 16'h0034, 16'h5555, 3'd1, 16'h0000);
    tick(); ex_valid_i = 1'b0;
    check_wb("t5_next", 1'b1, 3'd1, 16'h5555);
    check_eq("t5_next_pc", wb_pc_o, 16'h0034);

    $display("TB_RESULT checks=%0d failures=%0d", checks_n, fails_n);
    $finish;
  end

endmodule
